// File: rtl/exe_stage.sv
// exe_stage: execute stage of the ARM pipeline.
//
// Builds the second ALU operand (rotated immediate, shifted register or memory
// offset), executes exec_cmd, owns the NZCV status register, computes the branch
// target and registers everything into the EXE/MEM pipeline register.
//
// Configuration macro: EXE_REG_SHIFT_EN
//   defined   - register-form operand goes through the LSL/LSR/ASR/ROR shifter
//   undefined - register-form operand is val_rm unshifted
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   freeze, flush       hold / bubble control for the pipeline register
//   exec_cmd            ALU command
//   wb_en_in .. imm     control-unit outputs
//   pc_in               PC+4 of the instruction
//   val_rn, val_rm      register-file operands
//   shift_operand       instruction bits [11:0]
//   imm24               branch offset field
//   dest_in             destination register
//   alu_result, st_val, dest_out, *_out, branch_addr   registered results
//   status              NZCV register, N in bit 3

module exe_stage #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             flush,
   input  logic [3:0]       exec_cmd,
   input  logic             wb_en_in,
   input  logic             mem_r_en_in,
   input  logic             mem_w_en_in,
   input  logic             status_w_en_in,
   input  logic             branch_taken_in,
   input  logic             imm,
   input  logic [WIDTH-1:0] pc_in,
   input  logic [WIDTH-1:0] val_rn,
   input  logic [WIDTH-1:0] val_rm,
   input  logic [11:0]      shift_operand,
   input  logic [23:0]      imm24,
   input  logic [3:0]       dest_in,
   output logic [WIDTH-1:0] alu_result,
   output logic [WIDTH-1:0] st_val,
   output logic [3:0]       dest_out,
   output logic             wb_en_out,
   output logic             mem_r_en_out,
   output logic             mem_w_en_out,
   output logic             branch_taken_out,
   output logic [WIDTH-1:0] branch_addr,
   output logic [3:0]       status
);

   localparam logic [3:0] CmdMov = 4'b0001;
   localparam logic [3:0] CmdMvn = 4'b1001;
   localparam logic [3:0] CmdAdd = 4'b0010;
   localparam logic [3:0] CmdAdc = 4'b0011;
   localparam logic [3:0] CmdSub = 4'b0100;
   localparam logic [3:0] CmdSbc = 4'b0101;
   localparam logic [3:0] CmdAnd = 4'b0110;
   localparam logic [3:0] CmdOrr = 4'b0111;
   localparam logic [3:0] CmdEor = 4'b1000;

   // ---------------------------------------------------------------------------
   // Operand 2
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0]   imm_base;
   logic [4:0]         imm_rot;
   logic [2*WIDTH-1:0] imm_dbl;
   logic [WIDTH-1:0]   imm_val;
   logic [WIDTH-1:0]   reg_val;
   logic [WIDTH-1:0]   val2;

   assign imm_base = {{(WIDTH-8){1'b0}}, shift_operand[7:0]};
   assign imm_rot  = {shift_operand[11:8], 1'b0};
   // Rotate right by shifting a doubled copy; a rotate of 0 falls out naturally.
   assign imm_dbl  = {imm_base, imm_base} >> imm_rot;
   assign imm_val  = imm_dbl[WIDTH-1:0];

`ifdef EXE_REG_SHIFT_EN
   logic [4:0]         sh_amt;
   logic [2*WIDTH-1:0] ror_dbl;

   assign sh_amt  = shift_operand[11:7];
   assign ror_dbl = {val_rm, val_rm} >> sh_amt;

   always_comb begin
      reg_val = val_rm;
      unique case (shift_operand[6:5])
         2'b00: reg_val = val_rm << sh_amt;
         2'b01: reg_val = val_rm >> sh_amt;
         2'b10: reg_val = WIDTH'($signed(val_rm) >>> sh_amt);
         2'b11: reg_val = ror_dbl[WIDTH-1:0];
         default: reg_val = val_rm;
      endcase
   end
`else
   logic unused_shift_bits;
   assign unused_shift_bits = ^shift_operand[11:8];
   assign reg_val = val_rm;
`endif

   always_comb begin
      if (mem_r_en_in || mem_w_en_in) begin
         val2 = {{(WIDTH-12){1'b0}}, shift_operand};
      end else if (imm) begin
         val2 = imm_val;
      end else begin
         val2 = reg_val;
      end
   end

   // ---------------------------------------------------------------------------
   // ALU
   // ---------------------------------------------------------------------------
   logic             is_sub;
   logic             is_arith;
   logic             carry_in;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] result;
   logic             ovf;
   logic [3:0]       status_next;

   assign is_sub   = (exec_cmd == CmdSub) || (exec_cmd == CmdSbc);
   assign is_arith = is_sub || (exec_cmd == CmdAdd) || (exec_cmd == CmdAdc);

   always_comb begin
      carry_in = 1'b0;
      unique case (exec_cmd)
         CmdAdc, CmdSbc: carry_in = status[1];
         CmdSub:         carry_in = 1'b1;
         default:        carry_in = 1'b0;
      endcase
   end

   // Subtraction as A + ~B + cin so the carry out is directly NOT borrow.
   assign op_b = is_sub ? ~val2 : val2;
   assign sum  = {1'b0, val_rn} + {1'b0, op_b} + {{WIDTH{1'b0}}, carry_in};
   assign ovf  = (val_rn[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != val_rn[WIDTH-1]);

   always_comb begin
      result = '0;
      unique case (exec_cmd)
         CmdMov:                         result = val2;
         CmdMvn:                         result = ~val2;
         CmdAdd, CmdAdc, CmdSub, CmdSbc: result = sum[WIDTH-1:0];
         CmdAnd:                         result = val_rn & val2;
         CmdOrr:                         result = val_rn | val2;
         CmdEor:                         result = val_rn ^ val2;
         default:                        result = '0;
      endcase
   end

   always_comb begin
      status_next = {result[WIDTH-1], (result == '0),
                     is_arith ? sum[WIDTH] : status[1],
                     is_arith ? ovf : status[0]};
   end

   // ---------------------------------------------------------------------------
   // Branch target
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] branch_next;
   assign branch_next = pc_in + {{(WIDTH-26){imm24[23]}}, imm24, 2'b00};

   // ---------------------------------------------------------------------------
   // EXE/MEM pipeline register and status
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_result       <= '0;
         st_val           <= '0;
         dest_out         <= '0;
         wb_en_out        <= 1'b0;
         mem_r_en_out     <= 1'b0;
         mem_w_en_out     <= 1'b0;
         branch_taken_out <= 1'b0;
         branch_addr      <= '0;
         status           <= '0;
      end else if (flush) begin
         // Bubble wins over freeze; status is left alone.
         alu_result       <= '0;
         st_val           <= '0;
         dest_out         <= '0;
         wb_en_out        <= 1'b0;
         mem_r_en_out     <= 1'b0;
         mem_w_en_out     <= 1'b0;
         branch_taken_out <= 1'b0;
         branch_addr      <= '0;
      end else if (!freeze) begin
         alu_result       <= result;
         st_val           <= val_rm;
         dest_out         <= dest_in;
         wb_en_out        <= wb_en_in;
         mem_r_en_out     <= mem_r_en_in;
         mem_w_en_out     <= mem_w_en_in;
         branch_taken_out <= branch_taken_in;
         branch_addr      <= branch_next;
         if (status_w_en_in) begin
            status <= status_next;
         end
      end
   end

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

   logic        clk = 1'b0;
   logic        rst, freeze, flush;
   logic [3:0]  exec_cmd;
   logic        wb_en_in, mem_r_en_in, mem_w_en_in, status_w_en_in, branch_taken_in, imm;
   logic [31:0] pc_in, val_rn, val_rm;
   logic [11:0] shift_operand;
   logic [23:0] imm24;
   logic [3:0]  dest_in;
   logic [31:0] alu_result, st_val, branch_addr;
   logic [3:0]  dest_out, status;
   logic        wb_en_out, mem_r_en_out, mem_w_en_out, branch_taken_out;

   int checks = 0;
   int errors = 0;

   // Expected register contents, maintained by the reference model.
   logic [31:0] exp_alu, exp_st, exp_br;
   logic [3:0]  exp_dest, exp_status, exp_ctrl;

   exe_stage #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .exec_cmd(exec_cmd),
      .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .status_w_en_in(status_w_en_in), .branch_taken_in(branch_taken_in), .imm(imm),
      .pc_in(pc_in), .val_rn(val_rn), .val_rm(val_rm), .shift_operand(shift_operand),
      .imm24(imm24), .dest_in(dest_in), .alu_result(alu_result), .st_val(st_val),
      .dest_out(dest_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
      .mem_w_en_out(mem_w_en_out), .branch_taken_out(branch_taken_out),
      .branch_addr(branch_addr), .status(status)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got running, required finished");
      $fatal(1);
   end

   task automatic idle();
      rst = 0; freeze = 0; flush = 0; exec_cmd = 0; wb_en_in = 0; mem_r_en_in = 0;
      mem_w_en_in = 0; status_w_en_in = 0; branch_taken_in = 0; imm = 0;
      pc_in = 0; val_rn = 0; val_rm = 0; shift_operand = 0; imm24 = 0; dest_in = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: plain integer arithmetic on 64-bit values.
   task automatic model_step();
      longint mask = 64'hFFFF_FFFF;
      longint a, b, r, sa, sb, sv, c;
      int     amt;
      logic [3:0] st;
      a = longint'(val_rn);
      if (mem_r_en_in || mem_w_en_in) begin
         b = longint'(shift_operand);
      end else if (imm) begin
         amt = 2 * int'(shift_operand[11:8]);
         b = longint'(shift_operand[7:0]);
         b = ((b >> amt) | (b << (32 - amt))) & mask;
      end else begin
         b = longint'(val_rm);
`ifdef EXE_REG_SHIFT_EN
         amt = int'(shift_operand[11:7]);
         case (shift_operand[6:5])
            2'd0: b = (b << amt) & mask;
            2'd1: b = b >> amt;
            2'd2: b = (longint'($signed(val_rm)) >>> amt) & mask;
            default: b = ((b >> amt) | (b << (32 - amt))) & mask;
         endcase
`endif
      end
      c  = longint'(exp_status[1]);
      sa = longint'($signed(val_rn));
      sb = longint'($signed(b[31:0]));
      st = exp_status;
      sv = 0;
      case (exec_cmd)
         4'd1: r = b;
         4'd9: r = ~b & mask;
         4'd2, 4'd3: begin
            if (exec_cmd == 4'd2) c = 0;
            r = a + b + c;
            sv = sa + sb + c;
            st[1] = (r > mask);
            st[0] = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
            r = r & mask;
         end
         4'd4, 4'd5: begin
            c = (exec_cmd == 4'd4) ? 0 : 1 - c;   // borrow in
            st[1] = (a >= b + c);
            sv = sa - sb - c;
            st[0] = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
            r = (a - b - c) & mask;
         end
         4'd6: r = a & b;
         4'd7: r = a | b;
         4'd8: r = a ^ b;
         default: r = 0;
      endcase
      st[3] = r[31];
      st[2] = (r == 0);
      if (rst) begin
         exp_alu = 0; exp_st = 0; exp_dest = 0; exp_ctrl = 0; exp_br = 0; exp_status = 0;
      end else if (flush) begin
         exp_alu = 0; exp_st = 0; exp_dest = 0; exp_ctrl = 0; exp_br = 0;
      end else if (!freeze) begin
         exp_alu  = r[31:0];
         exp_st   = val_rm;
         exp_dest = dest_in;
         exp_ctrl = {wb_en_in, mem_r_en_in, mem_w_en_in, branch_taken_in};
         exp_br   = pc_in + {{6{imm24[23]}}, imm24, 2'b00};
         if (status_w_en_in) exp_status = st;
      end
   endtask

   task automatic test_reset();
      idle();
      rst = 1; exec_cmd = 4'd2; val_rn = 32'h1234; val_rm = 32'h55; wb_en_in = 1;
      status_w_en_in = 1; pc_in = 32'h40; dest_in = 4'd3;
      tick();
      checks++;
      if ({alu_result, st_val, branch_addr} !== 96'd0) begin
         errors++;
         $display("FAIL reset_data: got %h %h %h, required 0", alu_result, st_val, branch_addr);
      end
      checks++;
      if ({dest_out, wb_en_out, mem_r_en_out, mem_w_en_out, branch_taken_out, status} !== 12'd0)
      begin
         errors++;
         $display("FAIL reset_ctrl: got dest %h ctrl %b%b%b%b status %b, required 0",
                  dest_out, wb_en_out, mem_r_en_out, mem_w_en_out, branch_taken_out, status);
      end
      idle();
   endtask

   task automatic test_arith();
      idle();
      exec_cmd = 4'b0010; val_rn = 5; val_rm = 7; status_w_en_in = 1; wb_en_in = 1;
      tick();
      checks++;
      if (alu_result !== 32'd12 || status !== 4'b0000 || wb_en_out !== 1'b1) begin
         errors++;
         $display("FAIL add_5_7: got %0d status %b wb %b, required 12 status 0000 wb 1",
                  alu_result, status, wb_en_out);
      end
      exec_cmd = 4'b0100; val_rn = 5; val_rm = 5;
      tick();
      checks++;
      if (alu_result !== 32'd0 || status !== 4'b0110) begin
         errors++;
         $display("FAIL sub_5_5: got %h status %b, required 0 status 0110", alu_result, status);
      end
      exec_cmd = 4'b0010; val_rn = 32'hFFFF_FFFF; val_rm = 1;
      tick();
      checks++;
      if (alu_result !== 32'd0 || status !== 4'b0110) begin
         errors++;
         $display("FAIL add_carry: got %h status %b, required 0 status 0110",
                  alu_result, status);
      end
      exec_cmd = 4'b0011; val_rn = 1; val_rm = 2; status_w_en_in = 0;
      tick();
      checks++;
      if (alu_result !== 32'd4) begin
         errors++;
         $display("FAIL adc_carry_in: got %0d, required 4", alu_result);
      end
   endtask

   task automatic test_imm();
      idle();
      exec_cmd = 4'b0001; imm = 1; shift_operand = 12'h1FF;
      tick();
      checks++;
      if (alu_result !== 32'hC000_003F || status !== 4'b0110) begin
         errors++;
         $display("FAIL mov_imm_rot: got %h status %b, required c000003f status 0110",
                  alu_result, status);
      end
   endtask

   task automatic test_mem_branch();
      idle();
      exec_cmd = 4'b0010; mem_r_en_in = 1; wb_en_in = 1; val_rn = 32'h100;
      shift_operand = 12'h004; val_rm = 32'hFFFF_0000;
      tick();
      checks++;
      if (alu_result !== 32'h104 || mem_r_en_out !== 1'b1 || st_val !== 32'hFFFF_0000) begin
         errors++;
         $display("FAIL ldr_offset: got %h mem_r %b st %h, required 104 mem_r 1 st ffff0000",
                  alu_result, mem_r_en_out, st_val);
      end
      idle();
      branch_taken_in = 1; pc_in = 32'h20; imm24 = 24'hFFFFFE;
      tick();
      checks++;
      if (branch_addr !== 32'h18 || branch_taken_out !== 1'b1) begin
         errors++;
         $display("FAIL branch_back: got %h taken %b, required 18 taken 1",
                  branch_addr, branch_taken_out);
      end
   endtask

   task automatic test_freeze_flush();
      idle();
      exec_cmd = 4'b0010; val_rn = 3; val_rm = 4; status_w_en_in = 1; wb_en_in = 1;
      dest_in = 4'd5;
      tick();
      freeze = 1; exec_cmd = 4'b0100; val_rn = 9; val_rm = 9; dest_in = 4'd9;
      tick();
      tick();
      checks++;
      if (alu_result !== 32'd7 || status !== 4'b0000 || dest_out !== 4'd5
          || st_val !== 32'd4) begin
         errors++;
         $display("FAIL freeze_hold: got %0d status %b dest %0d st %0d, required 7 0000 5 4",
                  alu_result, status, dest_out, st_val);
      end
      flush = 1; branch_taken_in = 1; pc_in = 32'h100;
      tick();
      checks++;
      if ({alu_result, st_val, branch_addr, dest_out} !== 100'd0
          || {wb_en_out, mem_r_en_out, mem_w_en_out, branch_taken_out} !== 4'd0
          || status !== 4'b0000) begin
         errors++;
         $display("FAIL flush_freeze: got alu %h dest %0d wb %b br %b status %b, required 0",
                  alu_result, dest_out, wb_en_out, branch_taken_out, status);
      end
      idle();
      exec_cmd = 4'b0100; val_rn = 5; val_rm = 5; status_w_en_in = 1; wb_en_in = 1;
      dest_in = 4'd2;
      tick();
      rst = 1;
      tick();
      checks++;
      if (alu_result !== 32'd0 || status !== 4'b0000 || wb_en_out !== 1'b0
          || dest_out !== 4'd0) begin
         errors++;
         $display("FAIL rst_midstream: got %h status %b wb %b dest %0d, required 0",
                  alu_result, status, wb_en_out, dest_out);
      end
      idle();
   endtask

   task automatic test_shift();
      logic [31:0] want;
      idle();
`ifdef EXE_REG_SHIFT_EN
      want = 32'd16;
`else
      want = 32'd1;
`endif
      exec_cmd = 4'b0001; val_rm = 1; shift_operand = 12'h200;
      tick();
      checks++;
      if (alu_result !== want) begin
         errors++;
         $display("FAIL mov_lsl4: got %0d, required %0d", alu_result, want);
      end
   endtask

   task automatic test_random();
      idle();
      rst = 1;
      model_step();
      tick();
      rst = 0;
      for (int i = 0; i < 400; i++) begin
         rst             = ($urandom_range(0, 47) == 0);
         freeze          = ($urandom_range(0, 7) == 0);
         flush           = ($urandom_range(0, 9) == 0);
         exec_cmd        = 4'($urandom_range(0, 15));
         wb_en_in        = 1'($urandom);
         mem_r_en_in     = ($urandom_range(0, 5) == 0);
         mem_w_en_in     = ($urandom_range(0, 5) == 0);
         status_w_en_in  = 1'($urandom);
         branch_taken_in = ($urandom_range(0, 5) == 0);
         imm             = 1'($urandom);
         pc_in           = $urandom;
         val_rn          = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
         val_rm          = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
         shift_operand   = 12'($urandom);
         imm24           = 24'($urandom);
         dest_in         = 4'($urandom);
         model_step();
         tick();
         checks++;
         if (alu_result !== exp_alu) begin
            errors++;
            $display("FAIL rnd_alu[%0d]: got %h, required %h (cmd %h)", i, alu_result, exp_alu,
                     exec_cmd);
         end
         checks++;
         if (status !== exp_status) begin
            errors++;
            $display("FAIL rnd_status[%0d]: got %b, required %b", i, status, exp_status);
         end
         checks++;
         if ({wb_en_out, mem_r_en_out, mem_w_en_out, branch_taken_out} !== exp_ctrl
             || dest_out !== exp_dest) begin
            errors++;
            $display("FAIL rnd_ctrl[%0d]: got %b%b%b%b dest %h, required %b dest %h", i,
                     wb_en_out, mem_r_en_out, mem_w_en_out, branch_taken_out, dest_out,
                     exp_ctrl, exp_dest);
         end
         checks++;
         if (branch_addr !== exp_br || st_val !== exp_st) begin
            errors++;
            $display("FAIL rnd_br_st[%0d]: got %h %h, required %h %h", i, branch_addr, st_val,
                     exp_br, exp_st);
         end
      end
      idle();
   endtask

   initial begin
      idle();
      exp_alu = 0; exp_st = 0; exp_br = 0; exp_dest = 0; exp_ctrl = 0; exp_status = 0;
      test_reset();
      test_arith();
      test_imm();
      test_mem_branch();
      test_freeze_flush();
      test_shift();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the ARM pipeline, and the consumer of every control signal the control unit produces. It builds the second ALU operand (immediate rotate, register shift or memory offset) and executes `exec_cmd`. It owns the NZCV status register, computes the branch target, and registers all results into the EXE/MEM pipeline register. Freeze and flush inputs from the hazard and branch logic control that register.

## Interface
Parameters:
- `WIDTH`, 32: datapath width; only 32 is supported.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `freeze`  in  1  hold pipeline register and status.
- `flush`  in  1  load a bubble into the pipeline register.
- `exec_cmd`  in  4  ALU command: MOV 0001, MVN 1001, ADD/LDR/STR 0010, ADC 0011, SUB/CMP 0100, SBC 0101, AND/TST 0110, ORR 0111, EOR 1000; other codes give result 0.
- `wb_en_in`, `mem_r_en_in`, `mem_w_en_in`, `status_w_en_in`, `branch_taken_in`, `imm`  in  1 each  control-unit outputs.
- `pc_in`  in  32  PC+4 of the instruction.
- `val_rn`, `val_rm`  in  32  register-file operands.
- `shift_operand`  in  12  instruction bits [11:0].
- `imm24`  in  24  branch offset field.
- `dest_in`  in  4  destination register.
- `alu_result`  out  32  registered result.
- `st_val`  out  32  registered `val_rm` (store data).
- `dest_out`  out  4  registered destination register.
- `wb_en_out`, `mem_r_en_out`, `mem_w_en_out`, `branch_taken_out`  out  1 each  registered controls.
- `branch_addr`  out  32  registered branch target.
- `status`  out  4  NZCV register, N in bit 3.

## Operation
Val2 selection, in priority order:
- If `mem_r_en_in` or `mem_w_en_in` is set: val2 = zero-extended `shift_operand`.
- Else if `imm` is set: val2 = `{24'b0, shift_operand[7:0]}` rotated right by `2*shift_operand[11:8]`.
- Else: val2 = `val_rm` shifted by `shift_operand[11:7]`. Shift type in `[6:5]`: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes `val_rm` unchanged.

ALU, with A = `val_rn`, B = val2 and C = `status[1]`:
- MOV: B. MVN: ~B.
- ADD: A+B. ADC: A+B+C.
- SUB: A-B. SBC: A-B-!C.
- AND: A&B. ORR: A|B. EOR: A^B.
- Arithmetic is computed 33 bits wide.

Flags:
- N = result[31]; Z = (result == 0).
- Add-type commands: C = carry out of bit 31.
- Subtract-type commands: C = NOT borrow.
- V = signed overflow.
- MOV, MVN, AND, ORR, EOR: C and V are preserved.

Status update:
- `status` updates only when `status_w_en_in` is set and both `freeze` and `flush` are low.

Branch target:
- `branch_addr` = `pc_in` + `{sign-extended imm24, 2'b00}`, mod 2^32.
- Branch instructions never write status.

Pipeline register, updated on each rising edge with this priority:
- `rst`: all outputs and `status` go to 0.
- `flush`: all control outputs go to 0 and data outputs go to 0. This applies even when `freeze` is high.
- `freeze`: every register holds, including `status`.
- Otherwise: capture the new values.

## Timing
- Latency is 1 cycle from the inputs to every registered output. No combinational path from input to output.
- `status` updates on the same edge that captures the instruction. The next instruction's ADC or SBC therefore sees the new C with no stall.
- Reset mid-stream: the bubble appears on the first edge with `rst` high.

## Configuration
- `EXE_REG_SHIFT_EN` defined: register-form val2 uses the shifter described above.
- Undefined: register-form val2 = `val_rm` unshifted, and `shift_operand[11:5]` is ignored. Immediate rotation and memory offsets are unaffected.

## Test plan
- ADD with A=5, B=7 (register form, shift 0), `status_w_en_in`=1 → one cycle later `alu_result`=12, `status`=0000, `wb_en_out`=1.
- SUB with A=5, B=5 and S set → `alu_result`=0, `status`=0110. Then ADD with A=0xFFFFFFFF, B=1 and S set → `status`=0110. Then ADC with A=1, B=2 → `alu_result`=4.
- MOV with `imm`=1, `shift_operand`=0x1FF → `alu_result`=0xC000003F. With `status_w_en_in`=0, `status` is unchanged.
- LDR with `val_rn`=0x100, `shift_operand`=0x004 → `alu_result`=0x104, `mem_r_en_out`=1. Branch with `pc_in`=0x20, `imm24`=0xFFFFFE → `branch_addr`=0x18.
- Hold `freeze` for 2 cycles → outputs and `status` unchanged. Assert `flush` together with `freeze` → all outputs 0 on the next edge. `rst` mid-stream → outputs and `status` 0.
- MOV register form with `val_rm`=1 and LSL #4 (`shift_operand`=0x200) → `alu_result`=16 when `EXE_REG_SHIFT_EN` is defined, and 1 when it is not.
